// File: rtl/vip_rgb8882raw.sv
// RGB888 to Bayer RAW mosaicer. Tracks row and column position, picks one channel per pixel
// and flags lines or frames whose size differs from the expected geometry.
module vip_rgb8882raw #(
    parameter logic [1:0]  BAYER_PATTERN = 2'b00,
    parameter logic [12:0] IMG_HDISP     = 13'd640,
    parameter logic [12:0] IMG_VDISP     = 13'd480,
    parameter logic [4:0]  DATA_W        = 5'd8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pre_frame_vsync,
    input  logic              pre_frame_href,
    input  logic [DATA_W-1:0] pre_img_red,
    input  logic [DATA_W-1:0] pre_img_green,
    input  logic [DATA_W-1:0] pre_img_blue,
    output logic              post_frame_vsync,
    output logic              post_frame_href,
    output logic [DATA_W-1:0] post_img_raw,
    output logic              line_err,
    output logic              frame_err,
    output logic              frame_done
);

    localparam logic [12:0] CNT_MAX = 13'h1FFF;

    logic              vsync_d;
    logic              href_d;
    logic              primed;
    logic              line_active;
    logic              frame_active;
    logic [12:0]       col_cnt;
    logic [12:0]       row_cnt;
    logic [DATA_W-1:0] raw_q;
    logic              line_err_q;
    logic              frame_err_q;
    logic              frame_done_q;

    logic              vsync_rise;
    logic              vsync_fall;
    logic              href_rise;
    logic              href_fall;
    logic [12:0]       col_inc;
    logic [12:0]       row_inc;
    logic [12:0]       row_eff;
    logic [12:0]       row_end;
    logic              site_r;
    logic              site_c;
    logic [DATA_W-1:0] sample;

    // Edges are ignored in the first cycle after reset so that syncs already high
    // at release are not mistaken for the start of a frame or line.
    always_comb begin
        vsync_rise = primed &  pre_frame_vsync & ~vsync_d;
        vsync_fall = primed & ~pre_frame_vsync &  vsync_d;
        href_rise  = primed &  pre_frame_href  & ~href_d;
        href_fall  = primed & ~pre_frame_href  &  href_d;
        col_inc    = (col_cnt == CNT_MAX) ? col_cnt : col_cnt + 13'd1;
        row_inc    = (row_cnt == CNT_MAX) ? row_cnt : row_cnt + 13'd1;
        row_eff    = vsync_rise ? 13'd0 : row_cnt;
        row_end    = href_fall ? row_inc : row_cnt;
        // Each pattern is RGGB shifted by one row and/or one column.
        site_r     = row_eff[0] ^ BAYER_PATTERN[1];
        site_c     = col_cnt[0] ^ BAYER_PATTERN[0];
        case ({site_r, site_c})
            2'b00:   sample = pre_img_red;
            2'b11:   sample = pre_img_blue;
            default: sample = pre_img_green;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d      <= 1'b0;
            href_d       <= 1'b0;
            primed       <= 1'b0;
            line_active  <= 1'b0;
            frame_active <= 1'b0;
            col_cnt      <= 13'd0;
            row_cnt      <= 13'd0;
            raw_q        <= '0;
            line_err_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            vsync_d <= pre_frame_vsync;
            href_d  <= pre_frame_href;
            primed  <= 1'b1;
            col_cnt <= pre_frame_href ? col_inc : 13'd0;

            if (vsync_rise)
                row_cnt <= 13'd0;
            else if (href_fall)
                row_cnt <= row_inc;

            if (href_rise)
                line_active <= 1'b1;
            else if (href_fall)
                line_active <= 1'b0;

            if (vsync_rise)
                frame_active <= 1'b1;
            else if (vsync_fall)
                frame_active <= 1'b0;

            line_err_q   <= href_fall & line_active & (col_cnt != IMG_HDISP);
            frame_err_q  <= vsync_fall & frame_active & (row_end != IMG_VDISP);
            frame_done_q <= vsync_fall & frame_active;
            raw_q        <= pre_frame_href ? sample : '0;
        end
    end

    assign post_frame_vsync = vsync_d;
    assign post_frame_href  = href_d;
    assign post_img_raw     = raw_q;
    assign line_err         = line_err_q;
    assign frame_err        = frame_err_q;
    assign frame_done       = frame_done_q;

endmodule

// File: tb/tb_vip_rgb8882raw.sv
// Bench for vip_rgb8882raw: an RGGB and a BGGR instance share the stimulus; expected
// per-cycle outputs are queued when driven and compared one cycle later.
module tb_vip_rgb8882raw;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vs = 1'b0;
    logic       hs = 1'b0;
    logic [7:0] r_in = 8'd0;
    logic [7:0] g_in = 8'd0;
    logic [7:0] b_in = 8'd0;

    logic       vs_a, hs_a, lerr_a, ferr_a, done_a;
    logic       vs_b, hs_b, lerr_b, ferr_b, done_b;
    logic [7:0] raw_a, raw_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vip_rgb8882raw #(
        .BAYER_PATTERN(2'b00), .IMG_HDISP(13'd4), .IMG_VDISP(13'd2), .DATA_W(5'd8)
    ) dut_a (
        .clk(clk), .rst_n(rst_n),
        .pre_frame_vsync(vs), .pre_frame_href(hs),
        .pre_img_red(r_in), .pre_img_green(g_in), .pre_img_blue(b_in),
        .post_frame_vsync(vs_a), .post_frame_href(hs_a), .post_img_raw(raw_a),
        .line_err(lerr_a), .frame_err(ferr_a), .frame_done(done_a)
    );

    vip_rgb8882raw #(
        .BAYER_PATTERN(2'b11), .IMG_HDISP(13'd4), .IMG_VDISP(13'd2), .DATA_W(5'd8)
    ) dut_b (
        .clk(clk), .rst_n(rst_n),
        .pre_frame_vsync(vs), .pre_frame_href(hs),
        .pre_img_red(r_in), .pre_img_green(g_in), .pre_img_blue(b_in),
        .post_frame_vsync(vs_b), .post_frame_href(hs_b), .post_img_raw(raw_b),
        .line_err(lerr_b), .frame_err(ferr_b), .frame_done(done_b)
    );

    typedef struct packed {
        logic       v;
        logic       h;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       lerr;
        logic       ferr;
        logic       done;
        logic       chk_raw;
    } exp_t;

    typedef struct packed {
        int         nl;
        int         len0;
        int         len1;
        int         len2;
        int         lead;
        logic       rnd;
        logic [2:0] lerr;
        logic       ferr;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[6];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Bayer site table written out per pattern.
    function automatic logic [7:0] exp_raw(input logic [1:0] p, input int row, input int col,
                                           input logic [7:0] r, input logic [7:0] g,
                                           input logic [7:0] b);
        int site;
        site = (row % 2) * 2 + (col % 2);
        case (site)
            0: exp_raw = (p == 2'b00) ? r : (p == 2'b11) ? b : g;
            1: exp_raw = (p == 2'b01) ? r : (p == 2'b10) ? b : g;
            2: exp_raw = (p == 2'b10) ? r : (p == 2'b01) ? b : g;
            default: exp_raw = (p == 2'b11) ? r : (p == 2'b00) ? b : g;
        endcase
    endfunction

    task automatic cyc(input logic v, input logic h, input logic [7:0] r, input logic [7:0] g,
                       input logic [7:0] b, input logic [7:0] ea, input logic [7:0] eb,
                       input logic el, input logic ef, input logic ed, input logic cr);
        exp_t e;
        e = '{v: v, h: h, ra: ea, rb: eb, lerr: el, ferr: ef, done: ed, chk_raw: cr};
        sb.push_back(e);
        vs = v; hs = h; r_in = r; g_in = g; b_in = b;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("post_vsync", {15'd0, vs_a}, {15'd0, e.v});
        chk("post_href", {15'd0, hs_b}, {15'd0, e.h});
        if (e.chk_raw) begin
            chk("raw_rggb", {8'd0, raw_a}, {8'd0, e.ra});
            chk("raw_bggr", {8'd0, raw_b}, {8'd0, e.rb});
        end
        chk("line_err", {14'd0, lerr_b, lerr_a}, {14'd0, e.lerr, e.lerr});
        chk("frame_err", {14'd0, ferr_b, ferr_a}, {14'd0, e.ferr, e.ferr});
        chk("frame_done", {14'd0, done_b, done_a}, {14'd0, e.done, e.done});
    endtask

    task automatic idle(input logic v);
        cyc(v, 1'b0, 8'hAA, 8'hBB, 8'hCC, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic pixel(input logic v, input int row, input int col, input logic rnd);
        logic [7:0] r, g, b;
        r = rnd ? 8'($urandom_range(0, 255)) : 8'd10;
        g = rnd ? 8'($urandom_range(0, 255)) : 8'd20;
        b = rnd ? 8'($urandom_range(0, 255)) : 8'd30;
        cyc(v, 1'b1, r, g, b, exp_raw(2'b00, row, col, r, g, b), exp_raw(2'b11, row, col, r, g, b),
            1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic send_frame(input vec_t t, input int idx);
        int len;
        int e0 = errors;
        for (int i = 0; i < t.lead; i++) idle(1'b1);
        for (int l = 0; l < t.nl; l++) begin
            len = (l == 0) ? t.len0 : (l == 1) ? t.len1 : t.len2;
            for (int c = 0; c < len; c++) pixel(1'b1, l, c, t.rnd);
            cyc(1'b1, 1'b0, 8'hAA, 8'hBB, 8'hCC, 8'd0, 8'd0, t.lerr[l], 1'b0, 1'b0, 1'b1);
            idle(1'b1);
        end
        cyc(1'b0, 1'b0, 8'hAA, 8'hBB, 8'hCC, 8'd0, 8'd0, 1'b0, t.ferr, 1'b1, 1'b1);
        idle(1'b0);
        idle(1'b0);
        $display("frame %0d: %0d lines, lead %0d, new errors %0d", idx, t.nl, t.lead, errors - e0);
    endtask

    initial begin
        tbl[0] = '{nl: 2, len0: 4, len1: 4, len2: 0, lead: 2, rnd: 1'b0, lerr: 3'b000, ferr: 1'b0};
        tbl[1] = '{nl: 3, len0: 4, len1: 3, len2: 4, lead: 2, rnd: 1'b0, lerr: 3'b010, ferr: 1'b1};
        tbl[2] = '{nl: 2, len0: 4, len1: 4, len2: 0, lead: 0, rnd: 1'b0, lerr: 3'b000, ferr: 1'b0};
        tbl[3] = '{nl: 3, len0: 1, len1: 4, len2: 4, lead: 1, rnd: 1'b1, lerr: 3'b001, ferr: 1'b1};
        tbl[4] = '{nl: 1, len0: 5, len1: 0, len2: 0, lead: 2, rnd: 1'b1, lerr: 3'b001, ferr: 1'b1};
        tbl[5] = '{nl: 2, len0: 4, len1: 4, len2: 0, lead: 0, rnd: 1'b1, lerr: 3'b000, ferr: 1'b0};

        // Reset state, with active-looking inputs held during reset.
        vs = 1'b1; hs = 1'b1; r_in = 8'd10; g_in = 8'd20; b_in = 8'd30;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("reset_outputs", {9'd0, vs_a, hs_a, lerr_a, ferr_a, done_a, raw_a != 8'd0, raw_b != 8'd0},
                16'd0);
        end
        vs = 1'b0; hs = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(1'b0);
        idle(1'b0);
        $display("reset: checks %0d errors %0d", checks, errors);

        for (int i = 0; i < 6; i++) send_frame(tbl[i], i);

        // A line outside vsync after a 2-line frame: row counter is at 2, no errors.
        send_frame(tbl[0], 6);
        for (int c = 0; c < 4; c++) pixel(1'b0, 2, c, 1'b1);
        cyc(1'b0, 1'b0, 8'hAA, 8'hBB, 8'hCC, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        $display("href outside vsync: checks %0d errors %0d", checks, errors);

        // Reset pulsed mid-line: outputs clear at once, aborted frame raises nothing.
        idle(1'b1);
        pixel(1'b1, 0, 0, 1'b0);
        pixel(1'b1, 0, 1, 1'b0);
        vs = 1'b1; hs = 1'b1; r_in = 8'd10; g_in = 8'd20; b_in = 8'd30;
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset_raw", {8'd0, raw_a | raw_b}, 16'd0);
        chk("async_reset_sync", {14'd0, vs_a, hs_a}, 16'd0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk("held_reset", {11'd0, vs_a, hs_a, raw_a != 8'd0, lerr_a, done_a}, 16'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, 1'b1, 8'd10, 8'd20, 8'd30, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 8'd10, 8'd20, 8'd30, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 8'hAA, 8'hBB, 8'hCC, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 8'hAA, 8'hBB, 8'hCC, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        $display("mid-line reset: checks %0d errors %0d", checks, errors);
        send_frame(tbl[0], 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
